fetch_unit: RTL and testbench

- Instruction fetch stage of the SNACKS core. Sits directly upstream of the control LUT/decode stage.
- Owns the PC and reads the synchronous instruction memory.
- Buffers fetched words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Decode forms the LUT address as {instr[8], instr[7:4], zero_flag}. Execute redirects fetch on a taken BZ, BNZ or JMP, and decode stops fetch on halt.

---
 rtl/snacks_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 70 +++++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snacks_pkg.sv
// Shared types and defaults for the SNACKS core front end.
package snacks_pkg;

  localparam int unsigned INSTR_W_DEF = 9;
  localparam int unsigned PC_W_DEF    = 8;

  // Opcode field instr[7:4], as consumed by the decode LUT.
  typedef enum logic [3:0] {
    CLR, ADD, SUB, AND, OR, LD, ST, SL, SR, SET, BZ, BNZ, INC, DEC, JMP, ADC
  } op_code_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  // Queue entry layout at the default widths; the queue stores it as a flat vector.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO for fetched {instr, pc} words. Slot 0 is always the head, so the
// head output is a plain register. Flush wins over push; a same-cycle pop is harmless.
module fetch_queue #(
  parameter int unsigned ENTRY_W = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] slot0_q, slot0_d;
  logic [ENTRY_W-1:0] slot1_q, slot1_d;
  logic [1:0]         count_q, count_d;

  // Next-state: shift toward slot 0 on pop, append behind the last valid slot on push.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end else begin
            slot0_d = push_data;
          end
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_d = push_data;
          end else begin
            slot1_d = push_data;
          end
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign head  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// SNACKS instruction fetch: owns the PC, reads the synchronous instruction memory and
// hands words to decode through a 2-entry queue with a valid/ready handshake.
module fetch_unit
  import snacks_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic               halt_i,
  output logic               running_o,
  output logic [CNT_W-1:0]   retired_o
);

  localparam int unsigned ENTRY_W = INSTR_W + PC_W;

  fetch_state_t state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               clear_retired;

  logic [1:0]         q_count;
  logic [ENTRY_W-1:0] q_head;
  logic [ENTRY_W-1:0] push_data;
  logic [2:0]         occupancy;
  logic               in_run, do_halt, do_redirect, flush, pop, push, issue;

  // Halt beats redirect; both are only meaningful while running.
  assign in_run      = (state_q == RUN);
  assign do_halt     = in_run && halt_i;
  assign do_redirect = in_run && redirect_i && !halt_i;
  assign flush       = do_halt || do_redirect;

  assign instr_valid_o = (q_count != 2'd0);
  assign pop           = instr_valid_o && instr_ready_i;
  // A flush squashes the read that returns this cycle.
  assign push          = inflight_q && !flush;

  // Slots that will be occupied next cycle; issuing only below 2 keeps the queue from
  // overflowing. pop implies q_count >= 1, so this never underflows.
  assign occupancy = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = in_run && !flush && (occupancy < 3'd2);

  assign imem_rd_en = issue;
  assign imem_addr  = fetch_pc_q;
  assign push_data  = {imem_rdata, inflight_pc_q};

  fetch_queue #(
    .ENTRY_W (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (q_head),
    .count     (q_count)
  );

  assign instr_o   = q_head[ENTRY_W-1:PC_W];
  assign pc_o      = q_head[PC_W-1:0];
  assign running_o = in_run;
  assign retired_o = retired_q;

  // FSM next state and PC update.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    clear_retired = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          fetch_pc_d = START_PC;
        end
      end
      RUN: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end else if (issue) begin
          fetch_pc_d = fetch_pc_q + PC_W'(1);
        end
      end
      HALTED: begin
        if (start) begin
          state_d       = RUN;
          fetch_pc_d    = START_PC;
          clear_retired = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In-flight tracking and saturating retire count.
  always_comb begin
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    retired_d     = retired_q;
    if (clear_retired) begin
      retired_d = '0;
    end else if (pop && (retired_q != {CNT_W{1'b1}})) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= START_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      retired_q     <= retired_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs change 1 time unit after a rising edge;
// outputs are sampled on the falling edge. The instruction memory returns imem[n] = n.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, instr_ready_i, redirect_i, halt_i;
  logic [7:0]  redirect_pc_i;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [8:0]  imem_rdata = '0;
  logic [8:0]  instr_o;
  logic [7:0]  pc_o;
  logic        instr_valid_o, running_o;
  logic [15:0] retired_o;

  // Second instance starting near the top of the address space.
  logic        w_rd_en;
  logic [7:0]  w_addr;
  logic [8:0]  w_rdata = '0;
  logic [8:0]  w_instr;
  logic [7:0]  w_pc;
  logic        w_valid, w_running;
  logic [15:0] w_retired;
  logic        w_ready = 1'b1, w_redirect = 1'b0, w_halt = 1'b0;
  logic [7:0]  w_redirect_pc = 8'h00;
  logic [7:0]  wexp [4];

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.PC_W(8), .INSTR_W(9), .START_PC(8'h00), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_rd_en    (imem_rd_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .running_o     (running_o),
    .retired_o     (retired_o)
  );

  fetch_unit #(.PC_W(8), .INSTR_W(9), .START_PC(8'hFE), .CNT_W(16)) dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .imem_rd_en    (w_rd_en),
    .imem_addr     (w_addr),
    .imem_rdata    (w_rdata),
    .instr_o       (w_instr),
    .pc_o          (w_pc),
    .instr_valid_o (w_valid),
    .instr_ready_i (w_ready),
    .redirect_i    (w_redirect),
    .redirect_pc_i (w_redirect_pc),
    .halt_i        (w_halt),
    .running_o     (w_running),
    .retired_o     (w_retired)
  );

  // Synchronous memories: data for a strobed address appears after the next edge.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= {1'b0, imem_addr};
    if (w_rd_en)    w_rdata    <= {1'b0, w_addr};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue occupancy must never exceed its two slots.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_tests++;
      assert (dut.q_count <= 2'd2)
      else begin
        n_fail++;
        $error("FAIL queue_overflow: observed %0d expected <= 2", dut.q_count);
      end
    end
  end

  task automatic edge_then_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    reset = 1'b1; start = 1'b0; instr_ready_i = 1'b1;
    redirect_i = 1'b0; halt_i = 1'b0; redirect_pc_i = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    sample();
    check("rst_rd_en", imem_rd_en, 0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_addr_wrap", w_addr, 8'hFE);
    check("rst_valid", instr_valid_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_running", running_o, 0);
    check("rst_retired", retired_o, 0);

    // Start with ready high: addresses 0,1,2, then one instruction per cycle
    edge_then_drive(); start = 1'b1;
    sample(); check("idle_no_issue", imem_rd_en, 0);
    edge_then_drive(); start = 1'b0;
    sample();
    check("run_running", running_o, 1);
    check("run_rd_en0", imem_rd_en, 1);
    check("run_addr0", imem_addr, 8'h00);
    check("run_valid_early0", instr_valid_o, 0);
    edge_then_drive(); sample();
    check("run_rd_en1", imem_rd_en, 1);
    check("run_addr1", imem_addr, 8'h01);
    check("run_valid_early1", instr_valid_o, 0);
    edge_then_drive(); sample();
    check("first_valid", instr_valid_o, 1);
    check("first_instr", instr_o, 9'h000);
    check("first_pc", pc_o, 8'h00);
    check("run_addr2", imem_addr, 8'h02);
    check("first_retired", retired_o, 0);
    check("wrap_valid", w_valid, 1);
    check("wrap_pc0", w_pc, wexp[0]);
    for (int k = 1; k <= 5; k++) begin
      edge_then_drive(); sample();
      check("seq_valid", instr_valid_o, 1);
      check("seq_pc", pc_o, k);
      check("seq_instr", instr_o, k);
      check("seq_retired", retired_o, k);
      if (k < 4) check("wrap_pc", w_pc, wexp[k]);
    end

    // Backpressure: restart with decode stalled
    edge_then_drive(); reset = 1'b1; instr_ready_i = 1'b0;
    edge_then_drive(); reset = 1'b0;
    edge_then_drive(); start = 1'b1;
    edge_then_drive(); start = 1'b0;
    sample();
    edge_then_drive(); sample();
    edge_then_drive(); sample();
    check("bp_valid", instr_valid_o, 1);
    check("bp_pc_first", pc_o, 8'h00);
    check("bp_rd_en_full", imem_rd_en, 0);
    for (int k = 0; k < 3; k++) begin
      edge_then_drive(); sample();
      check("bp_hold_valid", instr_valid_o, 1);
      check("bp_hold_pc", pc_o, 8'h00);
      check("bp_hold_instr", instr_o, 9'h000);
      check("bp_rd_en", imem_rd_en, 0);
      check("bp_count", dut.q_count, 2);
    end
    edge_then_drive(); instr_ready_i = 1'b1;
    sample();
    check("bp_rel_pc0", pc_o, 8'h00);
    check("bp_rel_rd_en", imem_rd_en, 1);
    check("bp_rel_addr", imem_addr, 8'h02);
    edge_then_drive(); sample(); check("bp_rel_pc1", pc_o, 8'h01);
    edge_then_drive(); sample(); check("bp_rel_pc2", pc_o, 8'h02);

    // Redirect to 0x40 while pc 3 is popped
    edge_then_drive(); redirect_i = 1'b1; redirect_pc_i = 8'h40;
    sample();
    check("rd_pc3", pc_o, 8'h03);
    check("rd_no_issue", imem_rd_en, 0);
    check("rd_retired_before", retired_o, 3);
    edge_then_drive(); redirect_i = 1'b0; redirect_pc_i = 8'h00;
    sample();
    check("rd_flushed", instr_valid_o, 0);
    check("rd_retired_after", retired_o, 4);
    check("rd_target_issue", imem_rd_en, 1);
    check("rd_target_addr", imem_addr, 8'h40);
    edge_then_drive(); sample();
    check("rd_squashed", instr_valid_o, 0);
    check("rd_addr41", imem_addr, 8'h41);
    edge_then_drive(); sample();
    check("rd_target_valid", instr_valid_o, 1);
    check("rd_target_pc", pc_o, 8'h40);
    check("rd_target_instr", instr_o, 9'h040);

    // Halt together with redirect: halt wins
    edge_then_drive(); halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 8'h80;
    sample();
    check("halt_pc", pc_o, 8'h41);
    check("halt_no_issue", imem_rd_en, 0);
    edge_then_drive(); halt_i = 1'b0; redirect_i = 1'b0;
    sample();
    check("halt_running", running_o, 0);
    check("halt_valid", instr_valid_o, 0);
    check("halt_rd_en", imem_rd_en, 0);
    check("halt_retired", retired_o, 6);
    edge_then_drive(); sample();
    check("halted_valid", instr_valid_o, 0);
    check("halted_rd_en", imem_rd_en, 0);
    check("halted_state", running_o, 0);

    // Restart from HALTED, stall decode to build up occupancy
    edge_then_drive(); start = 1'b1; instr_ready_i = 1'b0;
    edge_then_drive(); start = 1'b0;
    sample();
    check("restart_running", running_o, 1);
    check("restart_retired", retired_o, 0);
    check("restart_addr", imem_addr, 8'h00);
    check("restart_rd_en", imem_rd_en, 1);
    edge_then_drive(); sample();
    check("restart_addr1", imem_addr, 8'h01);
    // One entry queued and one read in flight when reset is sampled
    edge_then_drive(); reset = 1'b1;
    sample();
    check("pre_rst_valid", instr_valid_o, 1);
    check("pre_rst_pc", pc_o, 8'h00);
    edge_then_drive(); reset = 1'b0;
    sample();
    check("mid_rst_valid", instr_valid_o, 0);
    check("mid_rst_instr", instr_o, 0);
    check("mid_rst_pc", pc_o, 0);
    check("mid_rst_rd_en", imem_rd_en, 0);
    check("mid_rst_addr", imem_addr, 8'h00);
    check("mid_rst_running", running_o, 0);
    check("mid_rst_retired", retired_o, 0);
    for (int k = 0; k < 2; k++) begin
      edge_then_drive(); sample();
      check("post_rst_no_push", instr_valid_o, 0);
      check("post_rst_rd_en", imem_rd_en, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
